// File: rtl/bias_add_stream.sv
// Per-channel signed bias adder over a CH_NUM-lane beat, 2-stage valid/ready pipeline
// with optional saturation and a sticky overflow flag.
module bias_add_stream #(
    parameter int unsigned NUM_WIDTH = 16,
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned CH_WIDTH  = $clog2(CH_NUM),
    parameter bit          SATURATE  = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bias_wr,
    input  logic [CH_WIDTH-1:0]         bias_addr,
    input  logic [NUM_WIDTH-1:0]        bias_data,
    input  logic [CH_NUM*NUM_WIDTH-1:0] up_data,
    input  logic                        up_valid,
    output logic                        up_ready,
    output logic [CH_NUM*NUM_WIDTH-1:0] dn_data,
    output logic                        dn_valid,
    input  logic                        dn_ready,
    output logic                        sat_flag,
    input  logic                        sat_clr
);

    localparam int unsigned SW = NUM_WIDTH + 1;
    localparam logic [NUM_WIDTH-1:0] MaxPos = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic [NUM_WIDTH-1:0] MinNeg = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    logic [NUM_WIDTH-1:0]        bias   [CH_NUM];
    logic [SW-1:0]               s1_sum [CH_NUM];
    logic                        s1_valid;
    logic [SW-1:0]               sum_d  [CH_NUM];
    logic [CH_NUM*NUM_WIDTH-1:0] clip_d;
    logic [CH_NUM-1:0]           ovf;
    logic                        advance;

    // Global stall: both stages move together whenever the output slot is free.
    assign advance  = !dn_valid || dn_ready;
    assign up_ready = advance;

    always_comb begin
        clip_d = '0;
        ovf    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            sum_d[i] = {up_data[i*NUM_WIDTH+NUM_WIDTH-1], up_data[i*NUM_WIDTH +: NUM_WIDTH]}
                     + {bias[i][NUM_WIDTH-1], bias[i]};
            ovf[i] = s1_sum[i][SW-1] ^ s1_sum[i][SW-2];
            if (ovf[i] && SATURATE) begin
                clip_d[i*NUM_WIDTH +: NUM_WIDTH] = s1_sum[i][SW-1] ? MinNeg : MaxPos;
            end else begin
                clip_d[i*NUM_WIDTH +: NUM_WIDTH] = s1_sum[i][NUM_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                bias[i] <= '0;
            end
        end else if (bias_wr) begin
            bias[bias_addr] <= bias_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                s1_sum[i] <= '0;
            end
            s1_valid <= 1'b0;
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (advance) begin
            s1_valid <= up_valid;
            if (up_valid) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    s1_sum[i] <= sum_d[i];
                end
            end
            dn_valid <= s1_valid;
            if (s1_valid) begin
                dn_data <= clip_d;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (advance && s1_valid && |ovf) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bias_add_stream.sv
// Directed and scoreboarded bench for bias_add_stream; a wrapping instance shares the stimulus.
module tb_bias_add_stream;

    logic        clk;
    logic        rst_n;
    logic        bias_wr;
    logic [1:0]  bias_addr;
    logic [15:0] bias_data;
    logic [63:0] up_data;
    logic        up_valid;
    logic        up_ready, up_ready_w;
    logic [63:0] dn_data, dn_data_w;
    logic        dn_valid, dn_valid_w;
    logic        dn_ready;
    logic        sat_flag, sat_flag_w;
    logic        sat_clr;

    int n_checks = 0;
    int n_errors = 0;
    int out_cnt  = 0;
    int sent     = 0;
    bit sb_on    = 0;
    bit hold     = 0;
    logic [63:0] held;
    logic [63:0] q[$];
    logic signed [15:0] tb_bias [4];

    bias_add_stream #(.NUM_WIDTH(16), .CH_NUM(4), .SATURATE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bias_wr(bias_wr), .bias_addr(bias_addr),
        .bias_data(bias_data), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
        .dn_data(dn_data), .dn_valid(dn_valid), .dn_ready(dn_ready), .sat_flag(sat_flag),
        .sat_clr(sat_clr)
    );

    bias_add_stream #(.NUM_WIDTH(16), .CH_NUM(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .bias_wr(bias_wr), .bias_addr(bias_addr),
        .bias_data(bias_data), .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready_w),
        .dn_data(dn_data_w), .dn_valid(dn_valid_w), .dn_ready(dn_ready),
        .sat_flag(sat_flag_w), .sat_clr(sat_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    // Saturating reference computed in plain integer arithmetic.
    function automatic logic [63:0] model(input logic [63:0] din);
        logic [63:0]        r;
        logic signed [15:0] l;
        int                 s;
        for (int i = 0; i < 4; i++) begin
            l = din[i*16 +: 16];
            s = int'(l) + int'(tb_bias[i]);
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[i*16 +: 16] = s[15:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n || !sb_on) begin
            q.delete();
            hold = 0;
        end else begin
            if (hold) begin
                check("hold_data", dn_data, held);
                check("hold_valid", 64'(dn_valid), 64'd1);
            end
            if (dn_valid && dn_ready) begin
                out_cnt++;
                if (q.size() > 0) check("sb_data", dn_data, q.pop_front());
                else check("sb_qsize", 64'(q.size()), 64'd1);
            end
            if (up_valid && up_ready) q.push_back(model(up_data));
            hold = dn_valid && !dn_ready;
            held = dn_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_bias(input int a, input logic [15:0] d);
        bias_wr   = 1'b1;
        bias_addr = a[1:0];
        bias_data = d;
        tick();
        bias_wr = 1'b0;
        tb_bias[a] = d;
    endtask

    initial begin
        logic [63:0] beats [8];
        int idx, cyc, base, wa;
        bit wp;
        logic [15:0] wd;

        rst_n = 0; bias_wr = 0; bias_addr = 0; bias_data = 0; up_data = 0;
        up_valid = 0; dn_ready = 1; sat_clr = 0;
        for (int i = 0; i < 4; i++) tb_bias[i] = 0;
        #2;
        check("rst_valid", 64'(dn_valid), 64'd0);
        check("rst_data", dn_data, 64'd0);
        check("rst_flag", 64'(sat_flag), 64'd0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Basic bias add
        wr_bias(0, 16'd1); wr_bias(1, 16'hFFFF); wr_bias(2, 16'd100); wr_bias(3, 16'd0);
        up_data = pack4(10, 10, 10, 10);
        up_valid = 1;
        @(negedge clk);
        check("basic_ready", 64'(up_ready), 64'd1);
        tick();
        up_valid = 0;
        @(negedge clk);
        check("basic_lat1", 64'(dn_valid), 64'd0);
        tick();
        @(negedge clk);
        check("basic_valid", 64'(dn_valid), 64'd1);
        check("basic_data", dn_data, pack4(11, 9, 110, 10));
        check("basic_flag", 64'(sat_flag), 64'd0);
        tick();

        // Overflow: saturating vs wrapping instance
        wr_bias(0, 16'h7000); wr_bias(1, 16'h9000); wr_bias(2, 16'd0); wr_bias(3, 16'd0);
        up_data = pack4(16'h2000, 16'h9000, 1, 2);
        up_valid = 1;
        tick();
        up_valid = 0;
        tick();
        @(negedge clk);
        check("sat_data", dn_data, pack4(16'h7FFF, 16'h8000, 1, 2));
        check("sat_flag", 64'(sat_flag), 64'd1);
        check("wrap_data", dn_data_w, pack4(16'h9000, 16'h2000, 1, 2));
        check("wrap_flag", 64'(sat_flag_w), 64'd1);
        tick();
        sat_clr = 1;
        tick();
        sat_clr = 0;
        @(negedge clk);
        check("clr_flag", 64'(sat_flag), 64'd0);
        check("clr_flag_w", 64'(sat_flag_w), 64'd0);
        tick();
        up_data = pack4(16'h2000, 0, 0, 0);
        up_valid = 1;
        tick();
        up_valid = 0;
        sat_clr = 1;
        tick();
        sat_clr = 0;
        @(negedge clk);
        check("set_wins", 64'(sat_flag), 64'd1);
        tick();

        // Bias write on the same edge a beat is accepted
        wr_bias(0, 16'd0); wr_bias(1, 16'd0); wr_bias(2, 16'd5); wr_bias(3, 16'd0);
        bias_wr = 1; bias_addr = 2'd2; bias_data = 16'd7;
        up_data = pack4(0, 0, 0, 0);
        up_valid = 1;
        tick();
        bias_wr = 0;
        tb_bias[2] = 7;
        up_data = pack4(1, 0, 0, 0);
        tick();
        up_valid = 0;
        @(negedge clk);
        check("wr_old", 64'(dn_data[47:32]), 64'd5);
        tick();
        @(negedge clk);
        check("wr_new", 64'(dn_data[47:32]), 64'd7);
        tick();

        // 8-beat stream with a 3-cycle downstream stall
        for (int k = 0; k < 8; k++) beats[k] = pack4(k * 3 + 1, -k, 1000 * k, 7);
        sb_on = 1;
        out_cnt = 0;
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            up_valid = (idx < 8);
            up_data  = (idx < 8) ? beats[idx] : 64'd0;
            dn_ready = !(c >= 4 && c < 7);
            @(negedge clk);
            if (!dn_ready) check("stall_ready", 64'(up_ready), 64'd0);
            if (up_valid && up_ready) idx++;
            tick();
        end
        check("stream_cnt", 64'(out_cnt), 64'd8);
        check("stream_q", 64'(q.size()), 64'd0);

        // Random traffic with occasional bias writes
        for (int i = 0; i < 4; i++) wr_bias(i, 16'($urandom));
        out_cnt = 0;
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            up_valid = 1'($urandom_range(0, 1));
            up_data  = {$urandom, $urandom};
            dn_ready = 1'($urandom_range(0, 1));
            wp = ($urandom_range(0, 15) == 0);
            wa = $urandom_range(0, 3);
            wd = 16'($urandom);
            bias_wr = wp; bias_addr = wa[1:0]; bias_data = wd;
            @(negedge clk);
            if (up_valid && up_ready) sent++;
            tick();
            if (wp) tb_bias[wa] = wd;
            cyc++;
        end
        bias_wr = 0;
        check("rand_done", 64'(sent), 64'd1000);
        up_valid = 0;
        dn_ready = 1;
        repeat (4) tick();
        check("rand_cnt", 64'(out_cnt), 64'(sent));
        check("rand_q", 64'(q.size()), 64'd0);

        // Full throughput with both sides held high
        base = out_cnt;
        up_valid = 1;
        for (int c = 0; c < 12; c++) begin
            up_data = {$urandom, $urandom};
            tick();
        end
        check("throughput", 64'(out_cnt - base), 64'd10);
        up_valid = 0;
        repeat (3) tick();
        check("tput_q", 64'(q.size()), 64'd0);
        sb_on = 0;

        // Asynchronous reset with beats in flight
        wr_bias(0, 16'h7FFF);
        up_data = pack4(16'h7FFF, 0, 0, 0);
        up_valid = 1;
        tick();
        tick();
        up_valid = 0;
        dn_ready = 0;
        #2;
        check("pre_rst_valid", 64'(dn_valid), 64'd1);
        check("pre_rst_flag", 64'(sat_flag), 64'd1);
        check("pre_rst_ready", 64'(up_ready), 64'd0);
        rst_n = 0;
        #1;
        check("arst_valid", 64'(dn_valid), 64'd0);
        check("arst_data", dn_data, 64'd0);
        check("arst_flag", 64'(sat_flag), 64'd0);
        check("arst_ready", 64'(up_ready), 64'd1);
        @(negedge clk);
        rst_n = 1;
        tick();
        dn_ready = 1;
        up_data = pack4(1, 2, -3, 4);
        up_valid = 1;
        tick();
        up_valid = 0;
        tick();
        @(negedge clk);
        check("post_rst_valid", 64'(dn_valid), 64'd1);
        check("post_rst_data", dn_data, pack4(1, 2, -3, 4));
        check("post_rst_flag", 64'(sat_flag), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bias_add_stream.md
Name: bias_add_stream

Overview:
- Multi-channel successor to the single-lane bias adder.
- Adds a per-channel signed bias, held in a writable register bank, to every lane of a CH_NUM-wide data beat.
- Optional saturation and a sticky overflow flag.
- Sits between the convolution accumulator output and the activation stage, with valid/ready handshakes on both sides and a 2-stage pipeline.

Parameters:
- NUM_WIDTH, 16: signed two's-complement width of each lane and each bias.
- CH_NUM, 4: number of parallel lanes/channels; power of two, >= 2.
- CH_WIDTH, $clog2(CH_NUM): width of the bias write address.
- SATURATE, 1: 1 = clamp on overflow; 0 = wrap modulo 2^NUM_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- bias_wr  in  1  bias bank write strobe.
- bias_addr  in  CH_WIDTH  channel selected for write.
- bias_data  in  NUM_WIDTH  signed bias value to write.
- up_data  in  CH_NUM*NUM_WIDTH  input beat; lane i occupies bits [i*NUM_WIDTH +: NUM_WIDTH].
- up_valid  in  1  input beat valid.
- up_ready  out  1  block accepts a beat this cycle.
- dn_data  out  CH_NUM*NUM_WIDTH  biased beat, same lane packing.
- dn_valid  out  1  output beat valid.
- dn_ready  in  1  downstream accepts a beat.
- sat_flag  out  1  sticky: at least one lane saturated or wrapped since last clear.
- sat_clr  in  1  clears sat_flag.

Behaviour:
- Reset (rst_n low, async, no clock needed):
  - all bias registers 0;
  - both stage valids 0, so dn_valid = 0;
  - dn_data = 0; sat_flag = 0.
  - Mid-stream reset discards in-flight beats.
- Bias bank:
  - On a clk edge with bias_wr = 1, bias[bias_addr] <= bias_data.
  - Writes are accepted regardless of stream state.
- Transfers:
  - Input transfer = up_valid & up_ready; output transfer = dn_valid & dn_ready.
- Pipeline stage 1 (add):
  - On an input transfer, per lane, s1_sum[i] = sext(up_data[i]) + sext(bias[i]), NUM_WIDTH+1 bits.
  - s1_valid <= 1 on an input transfer; else cleared when stage 1 advances empty.
  - The bias value used is the bank content before that edge. A beat accepted on the same edge as a bias write uses the old value; the next accepted beat uses the new value.
- Pipeline stage 2 (clip, drives dn_data/dn_valid):
  - Overflow when the two MSBs of s1_sum[i] differ.
  - SATURATE = 1: positive overflow gives 0x7FFF, negative overflow gives 0x8000 (generalised to NUM_WIDTH).
  - SATURATE = 0: low NUM_WIDTH bits are taken.
  - Overflow on any lane of a beat moving into stage 2 sets sat_flag.
- Flow control:
  - Global stall. advance = !dn_valid | dn_ready.
  - up_ready = advance (combinational from dn_valid and dn_ready).
  - When advance = 1, stage 1 moves to stage 2 and a new beat may enter stage 1 on the same edge.
  - When advance = 0, both stages and dn_data hold unchanged.
  - dn_data must never change while dn_valid = 1 and dn_ready = 0.
- Latency: 2 cycles from input transfer to dn_valid, with no stall.
- Throughput: 1 beat/cycle with dn_ready held high.
- No beat is dropped or duplicated under any up_valid/dn_ready pattern.
- Bubbles: if stage 1 is empty when advancing, dn_valid <= 0 and dn_data may hold its previous value.
- sat_clr:
  - sat_clr with no new overflow clears the flag next edge.
  - sat_clr and a new overflow on the same edge leaves sat_flag = 1 (set wins).

Test Plan:
- Reset, then write bias = {1, -1, 100, 0} to ch0..3; send beat {10, 10, 10, 10} with dn_ready = 1 -> dn_valid high 2 cycles after acceptance, dn_data = {11, 9, 110, 10}, sat_flag = 0.
- SATURATE = 1, ch0 bias 0x7000, lane0 = 0x2000; ch1 bias 0x9000, lane1 = 0x9000 -> lane0 = 0x7FFF, lane1 = 0x8000, sat_flag = 1. Repeat with SATURATE = 0 -> lanes 0x9000 and 0x2000, sat_flag = 1.
- Stream 8 consecutive beats; dn_ready low for 3 cycles mid-stream -> up_ready low during the stall, dn_data stable, all 8 outputs emerge in order, no loss or duplication.
- Random up_valid/dn_ready at 50% density over 1000 beats -> scoreboard matches the per-lane model exactly; throughput reaches 1/cycle when both are held high.
- bias_wr to ch2 (5 -> 7) on the same edge beat A is accepted, beat B accepted next cycle, lane2 input 0 -> A lane2 = 5, B lane2 = 7.
- Assert rst_n low while 2 beats are in flight and the bias bank is loaded -> dn_valid = 0 immediately (async), bias bank = 0, sat_flag = 0; the first post-reset beat is passed through unchanged.
